// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter that time-shares one external combinational ALU.
// Each operation runs IDLE (grant) -> EXEC (ALU evaluates) -> RESP (held until consumed).
module alu_share_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int ALU_CONTROL = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0_valid_i,
  input  logic [DATA_WIDTH-1:0]  req0_a_i,
  input  logic [DATA_WIDTH-1:0]  req0_b_i,
  input  logic [ALU_CONTROL-1:0] req0_op_i,
  output logic                   req0_ready_o,
  input  logic                   req1_valid_i,
  input  logic [DATA_WIDTH-1:0]  req1_a_i,
  input  logic [DATA_WIDTH-1:0]  req1_b_i,
  input  logic [ALU_CONTROL-1:0] req1_op_i,
  output logic                   req1_ready_o,
  output logic                   rsp0_valid_o,
  output logic [DATA_WIDTH-1:0]  rsp0_data_o,
  input  logic                   rsp0_ready_i,
  output logic                   rsp1_valid_o,
  output logic [DATA_WIDTH-1:0]  rsp1_data_o,
  input  logic                   rsp1_ready_i,
  output logic [DATA_WIDTH-1:0]  alu_a_o,
  output logic [DATA_WIDTH-1:0]  alu_b_o,
  output logic [ALU_CONTROL-1:0] alu_op_o,
  input  logic [DATA_WIDTH-1:0]  alu_res_i,
  output logic [1:0]             state_o
);

  // Handshakes: a transfer happens in any cycle where valid and ready are both 1;
  // ready never depends on the same-cycle ready of the other side, valid/data
  // are held by the producer until the transfer.
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_e;

  state_e                 state_q, state_d;
  logic                   ptr_q, ptr_d;
  logic                   owner_q, owner_d;
  logic [DATA_WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d;
  logic [ALU_CONTROL-1:0] op_q, op_d;

  logic any_valid, gnt_idx, grant, rsp_fire;

  assign any_valid = req0_valid_i | req1_valid_i;
  assign gnt_idx   = (req0_valid_i & req1_valid_i) ? ptr_q : req1_valid_i;
  assign grant     = (state_q == IDLE) & any_valid;
  assign rsp_fire  = (state_q == RESP) & (owner_q ? rsp1_ready_i : rsp0_ready_i);
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    if (grant) begin
      ptr_d   = ~gnt_idx;
      owner_d = gnt_idx;
      a_d     = gnt_idx ? req1_a_i  : req0_a_i;
      b_d     = gnt_idx ? req1_b_i  : req0_b_i;
      op_d    = gnt_idx ? req1_op_i : req0_op_i;
    end
    if (state_q == EXEC) res_d = alu_res_i;
  end

  // Ready is gated by rst_n so nothing is granted while reset is held.
  always_comb begin
    req0_ready_o = rst_n & grant & ~gnt_idx;
    req1_ready_o = rst_n & grant & gnt_idx;
    alu_a_o      = '0;
    alu_b_o      = '0;
    alu_op_o     = '0;
    rsp0_valid_o = 1'b0;
    rsp1_valid_o = 1'b0;
    rsp0_data_o  = '0;
    rsp1_data_o  = '0;
    if (state_q == EXEC) begin
      alu_a_o  = a_q;
      alu_b_o  = b_q;
      alu_op_o = op_q;
    end
    if (state_q == RESP) begin
      if (owner_q) begin
        rsp1_valid_o = 1'b1;
        rsp1_data_o  = res_q;
      end else begin
        rsp0_valid_o = 1'b1;
        rsp0_data_o  = res_q;
      end
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter ALU_CONTROL, default 4, ALU opcode width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports reqN_valid_i  input  1  requester N (N=0,1) holds a valid operation.
REQ-006 SHALL have ports reqN_a_i, reqN_b_i  input  DATA_WIDTH  requester N operands.
REQ-007 SHALL have ports reqN_op_i  input  ALU_CONTROL  requester N ALU opcode.
REQ-008 SHALL have ports reqN_ready_o  output  1  arbiter accepts requester N this cycle.
REQ-009 SHALL have ports rspN_valid_o  output  1  result for requester N is available.
REQ-010 SHALL have ports rspN_data_o  output  DATA_WIDTH  result for requester N.
REQ-011 SHALL have ports rspN_ready_i  input  1  requester N consumes its result.
REQ-012 SHALL have ports alu_a_o, alu_b_o  output  DATA_WIDTH  operands to the shared combinational ALU.
REQ-013 SHALL have port alu_op_o  output  ALU_CONTROL  opcode to the shared ALU.
REQ-014 SHALL have port alu_res_i  input  DATA_WIDTH  combinational ALU result.

Function
REQ-015 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-016 SHALL assert at most one reqN_ready_o per cycle, and only in IDLE.
REQ-017 SHALL, in IDLE, set reqN_ready_o to 1 for the granted requester when any reqN_valid_i=1; the handshake completes on reqN_valid_i & reqN_ready_o.
REQ-018 SHALL grant the sole valid requester when only one is valid.
REQ-019 SHALL grant the requester indicated by a 1-bit priority pointer when both are valid.
REQ-020 SHALL set the pointer to the non-granted requester index on every completed handshake.
REQ-021 SHALL, on handshake, latch operands, opcode and owner index into registers and move IDLE->EXEC.
REQ-022 SHALL drive alu_a_o/alu_b_o/alu_op_o only from the latched registers; these are 0 outside EXEC.
REQ-023 SHALL, in EXEC, capture alu_res_i into the result register and move EXEC->RESP; EXEC lasts exactly one cycle.
REQ-024 SHALL, in RESP, assert rspN_valid_o only for the owner and drive rspN_data_o with the result register; the non-owner's rsp_valid_o and rsp_data_o are 0.
REQ-025 SHALL hold the response stable while rspN_valid_o=1 and rspN_ready_i=0.
REQ-026 SHALL move RESP->IDLE on rspN_valid_o & rspN_ready_i; the next request is accepted no earlier than the following cycle.
REQ-027 SHALL give handshake-to-rsp_valid latency of exactly 2 cycles, and a minimum of 3 cycles per operation.
REQ-028 SHALL ignore reqN_valid_i and operand changes outside IDLE, and ignore rspN_ready_i when rspN_valid_o=0.
REQ-029 SHALL not modify the ALU result; width is DATA_WIDTH, with no truncation or extension.

Reset
REQ-030 SHALL, while rst_n=0, force state IDLE, pointer=0, and all outputs and internal registers to 0.
REQ-031 SHALL abandon any in-flight operation on reset, with no response delivered afterwards.
REQ-032 SHALL leave reset synchronously to clk; the first grant occurs no earlier than the first rising edge with rst_n=1.

Verification
REQ-033 SHALL test the single request: req0 a=5, b=3, op=ADD in IDLE -> req0_ready=1 at T; alu_a=5, alu_b=3 at T+1; rsp0_valid=1, rsp0_data=8 at T+2; rsp1_valid=0.
REQ-034 SHALL test simultaneous requests: both valid continuously, pointer=0 after reset -> grants alternate req0, req1, req0; each response goes to the correct port only.
REQ-035 SHALL test backpressure: rsp1_ready=0 for 4 cycles in RESP -> rsp1_valid and rsp1_data stable, req0/req1 ready=0 throughout; accepted on the cycle rsp1_ready=1, then IDLE.
REQ-036 SHALL test pointer update: only req1 valid, then both valid -> req1 is granted first, then req0 wins the tie.
REQ-037 SHALL test reset mid-operation: rst_n=0 during EXEC -> all outputs 0 immediately; after release no stale rsp_valid; a new req0 completes with 2-cycle latency.
REQ-038 SHALL test ignored stimulus: req0 operands change and req1 asserts during EXEC -> the latched result is unchanged; req1 is served only after RESP->IDLE.
